// File: rtl/peridot_pfc_bank_if.sv
// Command/response bus between the PFC Avalon interface (master) and one pin bank (slave).
interface peridot_pfc_bank_if;
   logic [36:0] pfc_cmd;
   logic [31:0] pfc_resp;

   modport master (output pfc_cmd, input pfc_resp);
   modport slave (input pfc_cmd, output pfc_resp);
endinterface

// File: rtl/peridot_pfc_bank.sv
// One 8-pin bank of the PERIDOT pin function controller: din/dout/pinfunc/funcpin registers,
// pin output mux, function input routing and a combinational read-back word.
module peridot_pfc_bank #(
   parameter int unsigned BANK_INDEX  = 0,
   parameter int unsigned PIN_COUNT   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     csi_clk,
   input  logic                     rsi_reset_n,
   peridot_pfc_bank_if.slave        pfc,
   input  logic [7:0]               coe_pin_in,
   output logic [7:0]               coe_pin_out,
   output logic [7:0]               coe_pin_oe,
   input  logic [7:0]               func_out,
   input  logic [7:0]               func_oe,
   output logic [7:0]               func_in
);
   localparam int unsigned PIN_W  = 8;
   localparam int unsigned WORD_W = 32;
   localparam logic [PIN_W-1:0]  PIN_MASK = PIN_W'((16'(1) << PIN_COUNT) - 16'(1));
   localparam logic [WORD_W-1:0] NIB_MASK = WORD_W'((64'(1) << (4 * PIN_COUNT)) - 64'(1));
   localparam logic [WORD_W-1:0] FUNCPIN_RST = 32'h8888_8888;

   logic [PIN_W-1:0]                    dout_q;
   logic [WORD_W-1:0]                   pinfunc_q;
   logic [WORD_W-1:0]                   funcpin_q;
   logic [SYNC_STAGES-1:0][PIN_W-1:0]   sync_q;

   logic              bank_hit;
   logic              wr_en;
   logic [1:0]        reg_sel;
   logic [WORD_W-1:0] wdata;
   logic [PIN_W-1:0]  pin_in_m;

   assign bank_hit = (pfc.pfc_cmd[35:34] == 2'(BANK_INDEX));
   assign wr_en    = pfc.pfc_cmd[36] & bank_hit;
   assign reg_sel  = pfc.pfc_cmd[33:32];
   assign wdata    = pfc.pfc_cmd[31:0];
   assign pin_in_m = coe_pin_in & PIN_MASK;

   // Register file and din synchroniser; absent pins are masked on entry so they always read 0.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         dout_q    <= '0;
         pinfunc_q <= '0;
         funcpin_q <= FUNCPIN_RST;
         sync_q    <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in_m};
         if (wr_en) begin
            unique case (reg_sel)
               2'd1: dout_q <= ((dout_q & wdata[15:8]) | (wdata[7:0] & ~wdata[15:8])) & PIN_MASK;
               2'd2: pinfunc_q <= wdata & NIB_MASK;
               2'd3: funcpin_q <= wdata;
               default: ;
            endcase
         end
      end
   end

   // Pin output mux: GPIO drives dout, codes 8-F borrow a function channel, anything else floats.
   always_comb begin
      logic [3:0] code;
      coe_pin_out = '0;
      coe_pin_oe  = '0;
      for (int i = 0; i < 8; i++) begin
         code = pinfunc_q[4*i +: 4];
         if (PIN_MASK[i]) begin
            if (code[3]) begin
               coe_pin_out[i] = func_out[code[2:0]];
               coe_pin_oe[i]  = func_oe[code[2:0]];
            end else if (code == 4'h1) begin
               coe_pin_out[i] = dout_q[i];
               coe_pin_oe[i]  = 1'b1;
            end
         end
      end
   end

   // Function input routing straight from the raw pins; 0x9 is the only constant-1 code.
   always_comb begin
      logic [3:0] src;
      func_in = '0;
      for (int n = 0; n < 8; n++) begin
         src = funcpin_q[4*n +: 4];
         if (!src[3]) func_in[n] = pin_in_m[src[2:0]];
         else         func_in[n] = (src == 4'h9);
      end
   end

   always_comb begin
      pfc.pfc_resp = '0;
      if (bank_hit) begin
         unique case (reg_sel)
            2'd0: pfc.pfc_resp = {24'h0, sync_q[SYNC_STAGES-1]};
            2'd1: pfc.pfc_resp = {24'h0, dout_q};
            2'd2: pfc.pfc_resp = pinfunc_q;
            2'd3: pfc.pfc_resp = funcpin_q;
            default: pfc.pfc_resp = '0;
         endcase
      end
   end
endmodule
